// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and flag bit indices for seq_alu
package alu_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_ADD = 3'b000;
   localparam opcode_t OP_SUB = 3'b001;
   localparam opcode_t OP_MUL = 3'b010;
   localparam opcode_t OP_DIV = 3'b011;
   localparam opcode_t OP_NOT = 3'b100;
   localparam opcode_t OP_XOR = 3'b101;
   localparam opcode_t OP_OR  = 3'b110;
   localparam opcode_t OP_AND = 3'b111;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DIV_RUN = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;
   localparam int FLAG_DZ    = 3;

endpackage

// File: rtl/seq_alu_div.sv
// rtl/seq_alu_div.sv - iterative restoring divider, one quotient bit per cycle
module seq_alu_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Load operands on start, then shift one dividend bit into the remainder per cycle
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (start) begin
         rem_d  = '0;
         quo_d  = dividend;
         dvs_d  = divisor;
         cnt_d  = CW'(WIDTH);
         busy_d = 1'b1;
      end else if (busy_q) begin
         // A borrow out of the trial subtraction means the divisor did not fit: restore
         if (trial[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered handshake ALU with iterative divide; flags gated by SEQ_ALU_FLAGS_EN
import alu_pkg::*;

module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] add_res, sub_res, mul_res, alu_res;
   logic             accept, deliver, is_div_nz;
   logic             div_start, div_busy, div_done;
   logic [WIDTH-1:0] div_quo;

   // A state outside the encoding behaves like IDLE so the block can never lock up
   assign in_ready  = (state_q == ST_DONE) ? out_ready : (state_q != ST_DIV_RUN);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;
   assign is_div_nz = (op == OP_DIV) && (b != '0);
   assign sub_res   = a - b;

`ifdef SEQ_ALU_FLAGS_EN
   logic [WIDTH:0]     add_full;
   logic [2*WIDTH-1:0] mul_full;
   logic [3:0]         flags_q, flags_d, alu_flags;
   assign add_full = {1'b0, a} + {1'b0, b};
   assign mul_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign add_res  = add_full[WIDTH-1:0];
   assign mul_res  = mul_full[WIDTH-1:0];
`else
   assign add_res  = a + b;
   assign mul_res  = a * b;
`endif

   // Single-cycle result; DIV only reaches here with a zero divisor
   always_comb begin
      case (op)
         OP_ADD:  alu_res = add_res;
         OP_SUB:  alu_res = sub_res;
         OP_MUL:  alu_res = mul_res;
         OP_DIV:  alu_res = '0;
         OP_NOT:  alu_res = ~a;
         OP_XOR:  alu_res = a ^ b;
         OP_OR:   alu_res = a | b;
         default: alu_res = a & b;
      endcase
   end

`ifdef SEQ_ALU_FLAGS_EN
   // Status flags for the single-cycle path
   always_comb begin
      alu_flags             = '0;
      alu_flags[FLAG_ZERO]  = (alu_res == '0);
      alu_flags[FLAG_CARRY] = (op == OP_ADD) ? add_full[WIDTH] :
                              (op == OP_SUB) ? (a < b) : 1'b0;
      alu_flags[FLAG_OVF]   = (op == OP_MUL) && (mul_full[2*WIDTH-1:WIDTH] != '0);
      alu_flags[FLAG_DZ]    = (op == OP_DIV) && (b == '0);
   end
`endif

   // Control FSM: a DONE slot that is being drained can take the next op like IDLE
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      div_start = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      flags_d   = flags_q;
`endif
      case (state_q)
         ST_DIV_RUN: begin
            if (div_done) begin
               result_d = div_quo;
`ifdef SEQ_ALU_FLAGS_EN
               flags_d            = '0;
               flags_d[FLAG_ZERO] = (div_quo == '0);
`endif
               state_d  = ST_DONE;
            end
         end
         default: begin
            if (accept) begin
               if (is_div_nz) begin
                  div_start = !div_busy;
                  state_d   = ST_DIV_RUN;
               end else begin
                  result_d = alu_res;
`ifdef SEQ_ALU_FLAGS_EN
                  flags_d  = alu_flags;
`endif
                  state_d  = ST_DONE;
               end
            end else if (deliver) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
`ifdef SEQ_ALU_FLAGS_EN
         flags_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
`ifdef SEQ_ALU_FLAGS_EN
         flags_q  <= flags_d;
`endif
      end
   end

   seq_alu_div #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (a),
      .divisor  (b),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   assign result = result_q;
`ifdef SEQ_ALU_FLAGS_EN
   assign flags  = flags_q;
`else
   assign flags  = 4'b0000;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH=8
module tb_seq_alu;

   localparam int W = 8;
`ifdef SEQ_ALU_FLAGS_EN
   localparam logic [3:0] FM = 4'hF;
`else
   localparam logic [3:0] FM = 4'h0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [2:0]   op_i;
   logic [W-1:0] a_i, b_i, result;
   logic [3:0]   flags;

   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   logic [11:0]  sb[$];

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op_i),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: {flags, result}
   function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [8:0]  s;
      logic [15:0] p;
      logic [7:0]  r;
      logic [3:0]  f;
      f = 4'b0;
      s = {1'b0, x} + {1'b0, y};
      p = {8'b0, x} * {8'b0, y};
      case (o)
         3'd0: begin r = s[7:0]; f[1] = s[8]; end
         3'd1: begin r = x - y; f[1] = (x < y); end
         3'd2: begin r = p[7:0]; f[2] = (p[15:8] != 8'd0); end
         3'd3: begin
            if (y == 8'd0) begin r = 8'd0; f[3] = 1'b1; end
            else r = x / y;
         end
         3'd4: r = ~x;
         3'd5: r = x ^ y;
         3'd6: r = x | y;
         default: r = x & y;
      endcase
      f[0] = (r == 8'd0);
      return {f & FM, r};
   endfunction

   // Present one op and hold it until accepted; pushes the expected result on the accept edge
   task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [11:0] exp);
      int waited;
      waited   = 0;
      op_i     = o;
      a_i      = x;
      b_i      = y;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         sb.push_back(exp);
         #1 in_valid = 1'b0;
      end
   endtask

   // Output monitor: compare every delivered result against the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) check("unexpected_output", {20'b0, flags, result}, 0);
         else begin
            logic [11:0] e;
            e = sb.pop_front();
            check("result", result, e[7:0]);
            check("flags", flags, e[11:8]);
         end
      end
   end

   initial begin
      int          busy_bad, stale;
      int          c0;
      logic [2:0]  ro;
      logic [7:0]  ra, rb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op_i = '0; a_i = '0; b_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_result", result, 0);
      check("reset_flags", flags, 0);
      @(posedge clk); #1;

      issue(3'd0, 8'd200, 8'd100, {4'b0010 & FM, 8'd44});
      @(negedge clk);
      check("add_latency", out_valid, 1);
      @(posedge clk); #1;

      issue(3'd1, 8'd5, 8'd7, {4'b0010 & FM, 8'hFE});
      issue(3'd2, 8'd20, 8'd20, {4'b0100 & FM, 8'h90});

      issue(3'd3, 8'd200, 8'd7, {4'b0000, 8'd28});
      busy_bad = 0;
      for (int i = 0; i <= W; i++) begin
         @(negedge clk);
         if (in_ready || out_valid) busy_bad++;
         @(posedge clk);
      end
      check("div_busy_cycles", busy_bad, 0);
      @(negedge clk);
      check("div_latency", out_valid, 1);
      @(posedge clk); #1;

      issue(3'd3, 8'd9, 8'd0, {4'b1001 & FM, 8'd0});
      @(negedge clk);
      check("div0_latency", out_valid, 1);
      @(posedge clk); #1;

      issue(3'd0, 8'd255, 8'd1, {4'b0011 & FM, 8'd0});
      @(posedge clk); #1;

      out_ready = 1'b0;
      issue(3'd5, 8'hF0, 8'hFF, {4'b0000, 8'h0F});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result", result, 8'h0F);
         check("bp_handshake", {out_valid, in_ready}, 2'b10);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      #1 check("bp_same_edge_ready", in_ready, 1);
      issue(3'd7, 8'h3C, 8'h0F, {4'b0000, 8'h0C});

      c0 = cyc;
      issue(3'd6, 8'h00, 8'h00, {4'b0001 & FM, 8'h00});
      issue(3'd4, 8'hFF, 8'h00, {4'b0001 & FM, 8'h00});
      issue(3'd2, 8'd16, 8'd16, {4'b0101 & FM, 8'h00});
      issue(3'd4, 8'h00, 8'h55, {4'b0000, 8'hFF});
      check("b2b_cycles", cyc - c0, 4);

      issue(3'd3, 8'd200, 8'd7, {4'b0000, 8'd28});
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("rst_no_stale", stale, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         issue(ro, ra, rb, model(ro, ra, rb));
      end

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
